// File: rtl/cl_serial_ctrl_pkg.sv
// cl_serial_ctrl_pkg: shared op codes, FSM states and counter sizing for the serial logic sequencer
package cl_serial_ctrl_pkg;
  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NOTA = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/cl_serial_ctrl_cl.sv
// cl: one-bit logic cell computing and/or/xor/not-a selected by S
module cl
  import cl_serial_ctrl_pkg::*;
(
  output logic       out,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] S
);
  // pick the operation for the single bit pair
  always_comb
    out = (S == OP_AND) ? (a & b) :
          (S == OP_OR)  ? (a | b) :
          (S == OP_XOR) ? (a ^ b) : ~a;
endmodule

// File: rtl/cl_serial_ctrl.sv
// cl_serial_ctrl: streams WIDTH-bit operands LSB first through one logic cell with start/busy/done handshake
module cl_serial_ctrl
  import cl_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, out_q, out_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             cell_out;

  cl u_cl (
    .out (cell_out),
    .a   (a_q[0]),
    .b   (b_q[0]),
    .S   (op_q)
  );

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign out  = out_q;
  assign zero = zero_q;

  // next state: shift one bit per RUN cycle, publish on the count==0 edge, accept start outside RUN
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    out_d   = out_q;
    zero_d  = zero_q;
    if (state_q == ST_RUN) begin
      res_d = {cell_out, res_q[WIDTH-1:1]};
      a_d   = a_q >> 1;
      b_d   = b_q >> 1;
      if (cnt_q == '0) begin
        out_d   = res_d;
        zero_d  = (res_d == '0);
        state_d = ST_DONE;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (start) begin
      a_d     = a;
      b_d     = b;
      op_d    = S;
      cnt_d   = CW'(WIDTH - 1);
      state_d = ST_RUN;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // state registers, all cleared so nothing starts as X
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end
endmodule

// File: tb/tb_cl_serial_ctrl.sv
// tb_cl_serial_ctrl: directed self-checking bench for the serial logic sequencer
module tb_cl_serial_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [1:0] S;
  logic [7:0] a, b;
  logic       busy, done, zero;
  logic [7:0] out;
  int tests = 0;
  int fails = 0;

  cl_serial_ctrl #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .S       (S),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] is,
                        input bit scramble, output int lat, output int bcnt, output int both);
    start = 1'b1; a = ia; b = ib; S = is;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = -1; bcnt = 0; both = 0;
    for (int n = 1; n <= 30; n++) begin
      if (busy) bcnt++;
      if (busy && done) both++;
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); S = 2'($urandom);
        start = (n == 3);
        if (n == 3) a = 8'hFF;
      end
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; S = '0;
    #12;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00 || zero !== 1'b1) begin
      fails++;
      $display("FAIL reset: got busy=%b done=%b out=%h zero=%b expected 0 0 00 1", busy, done, out, zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [7:0] exp [4] = '{8'h03, 8'hCF, 8'hCC, 8'h3C};
    int lat, bcnt, both;
    for (int i = 0; i < 4; i++) begin
      run_op(8'hC3, 8'h0F, ops[i], 1'b0, lat, bcnt, both);
      tests++;
      if (lat !== 8 || bcnt !== 8 || both !== 0) begin
        fails++;
        $display("FAIL op%0d timing: got lat=%0d busy_cycles=%0d overlap=%0d expected 8 8 0", i, lat, bcnt, both);
      end
      tests++;
      if (out !== exp[i] || zero !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL op%0d result: got out=%h zero=%b busy=%b expected %h 0 0", i, out, zero, busy, exp[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL op pulse: done=%b after one cycle, expected 0", done);
    end
  endtask

  task automatic test_ignore();
    int lat, bcnt, both, extra;
    run_op(8'hF0, 8'h0F, 2'b00, 1'b1, lat, bcnt, both);
    tests++;
    if (lat !== 8 || out !== 8'h00 || zero !== 1'b1) begin
      fails++;
      $display("FAIL ignore: got lat=%0d out=%h zero=%b expected 8 00 1", lat, out, zero);
    end
    extra = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    tests++;
    if (extra !== 0 || out !== 8'h00) begin
      fails++;
      $display("FAIL ignore extra: got active_cycles=%0d out=%h expected 0 00", extra, out);
    end
  endtask

  task automatic test_back_to_back();
    int edges [$];
    int bad_busy = 0;
    int bad_out = 0;
    start = 1'b1; a = 8'hAA; b = 8'h55; S = 2'b10;
    @(posedge clk);
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        edges.push_back(n);
        if (out !== 8'hFF) bad_out++;
      end
      if (busy === done) bad_busy++;
    end
    start = 1'b0;
    tests++;
    if (edges.size() !== 3 || edges[0] !== 8 || edges[1] !== 17 || edges[2] !== 26) begin
      fails++;
      $display("FAIL b2b spacing: got %0d pulses first=%0d expected 3 pulses at 8,17,26",
               edges.size(), (edges.size() > 0) ? edges[0] : -1);
    end
    tests++;
    if (bad_out !== 0 || bad_busy !== 0) begin
      fails++;
      $display("FAIL b2b values: got bad_out=%0d bad_busy=%0d expected 0 0", bad_out, bad_busy);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int seen = 0;
    start = 1'b1; a = 8'hFF; b = 8'hFF; S = 2'b00;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL areset pre: busy=%b expected 1", busy);
    end
    #1 reset_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || out !== 8'h00 || zero !== 1'b1) begin
      fails++;
      $display("FAIL areset: got busy=%b done=%b out=%h zero=%b expected 0 0 00 1", busy, done, out, zero);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    tests++;
    if (seen !== 0 || out !== 8'h00) begin
      fails++;
      $display("FAIL areset after: got active_cycles=%0d out=%h expected 0 00", seen, out);
    end
  endtask

  task automatic test_idle();
    int lat, bcnt, both;
    int bad = 0;
    run_op(8'hC3, 8'h0F, 2'b00, 1'b0, lat, bcnt, both);
    tests++;
    if (lat !== 8 || out !== 8'h03) begin
      fails++;
      $display("FAIL idle setup: got lat=%0d out=%h expected 8 03", lat, out);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); S = 2'($urandom);
      tests++;
      if (out !== 8'h03 || zero !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        fails++; bad++;
        $display("FAIL idle cycle %0d: got out=%h zero=%b done=%b busy=%b expected 03 0 0 0",
                 n, out, zero, done, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_ignore();
    test_back_to_back();
    test_async_reset();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
